// File: rtl/pipeline_memory_stage_mc_if.sv
// Bundle of the memory-stage handshakes: upstream issue, downstream result,
// data-memory port and forwarding view.
interface pipeline_memory_stage_mc_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 5
);
    // valid/ready: a beat transfers on a rising edge where both are high;
    // the producer holds valid and payload stable until that edge.
    logic                    in_valid;
    logic                    in_ready;
    logic [ADDR_WIDTH-1:0]   in_pc;
    logic                    in_load;
    logic                    in_store;
    logic [1:0]              in_size;
    logic                    in_unsigned;
    logic [ADDR_WIDTH-1:0]   in_addr;
    logic [DATA_WIDTH-1:0]   in_store_data;
    logic                    in_rw_en;
    logic [REG_ID_WIDTH-1:0] in_rw_id;
    logic                    in_rw_ready;
    logic [DATA_WIDTH-1:0]   in_rw_data;

    logic                    out_valid;
    logic                    out_ready;
    logic [ADDR_WIDTH-1:0]   out_pc;
    logic                    out_rw_en;
    logic [REG_ID_WIDTH-1:0] out_rw_id;
    logic                    out_rw_ready;
    logic [DATA_WIDTH-1:0]   out_rw_data;
    logic                    out_misaligned;

    logic                    dm_req;
    logic                    dm_ack;
    logic                    dm_we;
    logic [ADDR_WIDTH-1:0]   dm_addr;
    logic [DATA_WIDTH/8-1:0] dm_wstrb;
    logic [DATA_WIDTH-1:0]   dm_wdata;
    logic [DATA_WIDTH-1:0]   dm_rdata;

    logic [REG_ID_WIDTH-1:0] fwd_id;
    logic                    fwd_ready;
    logic [DATA_WIDTH-1:0]   fwd_data;

    logic                    dbg_state;

    modport slave (
        input  in_valid, in_pc, in_load, in_store, in_size, in_unsigned, in_addr,
               in_store_data, in_rw_en, in_rw_id, in_rw_ready, in_rw_data,
               out_ready, dm_ack, dm_rdata,
        output in_ready, out_valid, out_pc, out_rw_en, out_rw_id, out_rw_ready,
               out_rw_data, out_misaligned, dm_req, dm_we, dm_addr, dm_wstrb,
               dm_wdata, fwd_id, fwd_ready, fwd_data, dbg_state
    );

    modport master (
        output in_valid, in_pc, in_load, in_store, in_size, in_unsigned, in_addr,
               in_store_data, in_rw_en, in_rw_id, in_rw_ready, in_rw_data,
               out_ready, dm_ack, dm_rdata,
        input  in_ready, out_valid, out_pc, out_rw_en, out_rw_id, out_rw_ready,
               out_rw_data, out_misaligned, dm_req, dm_we, dm_addr, dm_wstrb,
               dm_wdata, fwd_id, fwd_ready, fwd_data, dbg_state
    );
endinterface

// File: rtl/pipeline_memory_stage_mc.sv
// Multi-cycle pipeline memory stage: IDLE/ACCESS FSM, lane steering, output register.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module pipeline_memory_stage_mc #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int REG_ID_WIDTH = 5
) (
    input logic clock,
    input logic reset,
    pipeline_memory_stage_mc_if.slave bus
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(NB);
    localparam int SIDXW = $clog2(DATA_WIDTH);

    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_e;

    state_e state_q, state_d;

    logic                    req_load_q, req_store_q, req_uns_q;
    logic [1:0]              req_size_q;
    logic [ADDR_WIDTH-1:0]   req_pc_q, req_addr_q;
    logic [DATA_WIDTH-1:0]   req_sdata_q, req_rw_data_q;
    logic                    req_rw_en_q, req_rw_ready_q;
    logic [REG_ID_WIDTH-1:0] req_rw_id_q;

    logic                    out_valid_q, out_valid_d;
    logic [ADDR_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic                    out_rw_en_q, out_rw_en_d;
    logic [REG_ID_WIDTH-1:0] out_rw_id_q, out_rw_id_d;
    logic                    out_rw_ready_q, out_rw_ready_d;
    logic [DATA_WIDTH-1:0]   out_rw_data_q, out_rw_data_d;
    logic                    out_mis_q, out_mis_d;

    logic                    in_ready, dm_req;
    logic                    in_fire, in_mem, trap, go_access, ack_fire;
    logic [1:0]              in_esize;
    logic [OFFW-1:0]         lane;
    logic [SIDXW-1:0]        sign_idx;
    logic [DATA_WIDTH-1:0]   shifted, lmask, ld_ext, wdata;
    logic [NB-1:0]           wstrb;
    logic                    sign;
    logic [DATA_WIDTH:0]     res_in, res_acc;

    function automatic logic [1:0] clamp_size(input logic [1:0] s);
        return (int'(s) > OFFW) ? 2'(OFFW) : s;
    endfunction

    function automatic logic [OFFW-1:0] size_mask(input logic [1:0] s);
        return OFFW'((32'd1 << s) - 32'd1);
    endfunction

    // Result priority: no writeback, then upstream-produced data, then load data.
    function automatic logic [DATA_WIDTH:0] pick_result(
        input logic rw_en, input logic rw_ready, input logic [DATA_WIDTH-1:0] rw_data,
        input logic is_load, input logic [DATA_WIDTH-1:0] load_data);
        if (!rw_en)        return {1'b1, {DATA_WIDTH{1'b0}}};
        else if (rw_ready) return {1'b1, rw_data};
        else if (is_load)  return {1'b1, load_data};
        else               return {1'b0, {DATA_WIDTH{1'b0}}};
    endfunction

    always_comb begin
        in_esize = clamp_size(bus.in_size);
        in_mem   = bus.in_load || bus.in_store;
`ifdef MEM_MISALIGN_TRAP_EN
        trap     = in_mem && (|(bus.in_addr[OFFW-1:0] & size_mask(in_esize)));
`else
        trap     = 1'b0;
`endif
        in_fire   = bus.in_valid && in_ready;
        go_access = in_fire && in_mem && !trap;
        ack_fire  = (state_q == S_ACCESS) && bus.dm_ack;
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (go_access) state_d = S_ACCESS;
            S_ACCESS: if (ack_fire)  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = (state_q == S_IDLE) && (!out_valid_q || bus.out_ready);
        dm_req        = (state_q == S_ACCESS);
        bus.dbg_state = state_q;
    end

    // Misaligned addresses are truncated to the access size when steering lanes.
    always_comb begin
        lane     = req_addr_q[OFFW-1:0] & ~size_mask(req_size_q);
        shifted  = bus.dm_rdata >> {lane, 3'b000};
        sign_idx = SIDXW'((32'd8 << req_size_q) - 32'd1);
        lmask    = ~({DATA_WIDTH{1'b1}} << (32'd8 << req_size_q));
        sign     = !req_uns_q && shifted[sign_idx];
        ld_ext   = (shifted & lmask) | (sign ? ~lmask : '0);
        wdata    = '0;
        wstrb    = '0;
        for (int i = 0; i < NB; i++) begin
            wdata[i*8 +: 8] = req_sdata_q[(i % (1 << req_size_q))*8 +: 8];
            wstrb[i] = req_store_q && ((i >> req_size_q) == (int'(lane) >> req_size_q));
        end
    end

    always_comb begin
        res_in         = pick_result(bus.in_rw_en, bus.in_rw_ready, bus.in_rw_data,
                                     1'b0, '0);
        res_acc        = pick_result(req_rw_en_q, req_rw_ready_q, req_rw_data_q,
                                     req_load_q, ld_ext);
        out_valid_d    = out_valid_q && !bus.out_ready;
        out_pc_d       = out_pc_q;
        out_rw_en_d    = out_rw_en_q;
        out_rw_id_d    = out_rw_id_q;
        out_rw_ready_d = out_rw_ready_q;
        out_rw_data_d  = out_rw_data_q;
        out_mis_d      = out_mis_q;
        if (in_fire && !go_access) begin
            out_valid_d    = 1'b1;
            out_pc_d       = bus.in_pc;
            out_rw_en_d    = bus.in_rw_en;
            out_rw_id_d    = bus.in_rw_id;
            out_rw_ready_d = trap ? 1'b1 : res_in[DATA_WIDTH];
            out_rw_data_d  = trap ? '0 : res_in[DATA_WIDTH-1:0];
            out_mis_d      = trap;
        end else if (ack_fire) begin
            out_valid_d    = 1'b1;
            out_pc_d       = req_pc_q;
            out_rw_en_d    = req_rw_en_q;
            out_rw_id_d    = req_rw_id_q;
            out_rw_ready_d = res_acc[DATA_WIDTH];
            out_rw_data_d  = res_acc[DATA_WIDTH-1:0];
            out_mis_d      = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_pc_q       <= '0;
            out_rw_en_q    <= 1'b0;
            out_rw_id_q    <= '0;
            out_rw_ready_q <= 1'b0;
            out_rw_data_q  <= '0;
            out_mis_q      <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_pc_q       <= out_pc_d;
            out_rw_en_q    <= out_rw_en_d;
            out_rw_id_q    <= out_rw_id_d;
            out_rw_ready_q <= out_rw_ready_d;
            out_rw_data_q  <= out_rw_data_d;
            out_mis_q      <= out_mis_d;
        end
    end

    // Load wins if both selects are raised; the access is then a plain read.
    always_ff @(posedge clock) begin
        if (reset) begin
            req_load_q     <= 1'b0;
            req_store_q    <= 1'b0;
            req_uns_q      <= 1'b0;
            req_size_q     <= '0;
            req_pc_q       <= '0;
            req_addr_q     <= '0;
            req_sdata_q    <= '0;
            req_rw_en_q    <= 1'b0;
            req_rw_id_q    <= '0;
            req_rw_ready_q <= 1'b0;
            req_rw_data_q  <= '0;
        end else if (go_access) begin
            req_load_q     <= bus.in_load;
            req_store_q    <= bus.in_store && !bus.in_load;
            req_uns_q      <= bus.in_unsigned;
            req_size_q     <= in_esize;
            req_pc_q       <= bus.in_pc;
            req_addr_q     <= bus.in_addr;
            req_sdata_q    <= bus.in_store_data;
            req_rw_en_q    <= bus.in_rw_en;
            req_rw_id_q    <= bus.in_rw_id;
            req_rw_ready_q <= bus.in_rw_ready;
            req_rw_data_q  <= bus.in_rw_data;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.dm_req         = dm_req;
    assign bus.dm_we          = req_store_q && dm_req;
    assign bus.dm_addr        = {req_addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    assign bus.dm_wstrb       = wstrb & {NB{dm_req}};
    assign bus.dm_wdata       = wdata;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_pc         = out_pc_q;
    assign bus.out_rw_en      = out_rw_en_q;
    assign bus.out_rw_id      = out_rw_id_q;
    assign bus.out_rw_ready   = out_rw_ready_q;
    assign bus.out_rw_data    = out_rw_data_q;
    assign bus.out_misaligned = out_mis_q;
    assign bus.fwd_id         = out_valid_q ? out_rw_id_q : '0;
    assign bus.fwd_ready      = out_valid_q ? out_rw_ready_q : 1'b1;
    assign bus.fwd_data       = out_valid_q ? out_rw_data_q : '0;
endmodule

// File: doc/pipeline_memory_stage_mc.md
PIPELINE_MEMORY_STAGE_MC -- requirements
Module: pipeline_memory_stage_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32: register and memory data width; legal values 32 and 64.
REQ-002 Parameter ADDR_WIDTH, default 32: data-memory byte address width.
REQ-003 Parameter REG_ID_WIDTH, default 5: register identifier width.
REQ-004 clock  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream handshake; a transfer occurs when both are high at a rising edge.
REQ-007 in_pc  in  ADDR_WIDTH  program counter; passed through.
REQ-008 in_load / in_store  in  1 / 1  memory operation select; both high is illegal.
REQ-009 in_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_WIDTH=64).
REQ-010 in_unsigned  in  1  load zero-extends when high, sign-extends when low.
REQ-011 in_addr / in_store_data  in  ADDR_WIDTH / DATA_WIDTH  byte address; store source data.
REQ-012 in_rw_en / in_rw_id  in  1 / REG_ID_WIDTH  register write enable and destination.
REQ-013 in_rw_ready / in_rw_data  in  1 / DATA_WIDTH  write data already produced upstream, and its value.
REQ-014 out_valid / out_ready  out / in  1 / 1  downstream handshake.
REQ-015 out_pc, out_rw_en, out_rw_id, out_rw_ready, out_rw_data  out  as inputs  registered result.
REQ-016 out_misaligned  out  1  misaligned-access flag (Configuration only; constant 0 otherwise).
REQ-017 dm_req / dm_ack  out / in  1 / 1  memory request and completion.
REQ-018 dm_we, dm_addr, dm_wstrb, dm_wdata  out  1, ADDR_WIDTH, DATA_WIDTH/8, DATA_WIDTH  request attributes.
REQ-019 dm_rdata  in  DATA_WIDTH  read data, valid in the dm_ack cycle.
REQ-020 fwd_id, fwd_ready, fwd_data  out  REG_ID_WIDTH, 1, DATA_WIDTH  forwarding view of the output register.

Function
REQ-021 States SHALL be IDLE and ACCESS; in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready).
REQ-022 An accepted non-memory instruction SHALL appear at the output on the next edge (latency 1).
REQ-023 An accepted load/store SHALL be latched and enter ACCESS; dm_req SHALL assert from the following cycle.
REQ-024 In ACCESS, dm_req and all dm_* attributes SHALL be held stable until the edge where dm_ack is high.
REQ-025 On the dm_ack edge the result SHALL load into the output register, dm_req SHALL drop and the state SHALL return to IDLE; minimum memory latency is 2 cycles.
REQ-026 dm_ack outside ACCESS SHALL be ignored.
REQ-027 dm_addr SHALL be in_addr with the low log2(DATA_WIDTH/8) bits cleared.
REQ-028 Stores SHALL replicate the low 2^in_size bytes of data across dm_wdata and set dm_wstrb to the selected lanes only; loads SHALL drive dm_wstrb to 0 and dm_we to 0.
REQ-029 Loads SHALL extract the addressed lane of dm_rdata and extend it per in_unsigned to DATA_WIDTH.
REQ-030 Result SHALL be: rw_en low -> ready 1, data 0; in_rw_ready high -> pass in_rw_data; load -> ready 1, extracted data; otherwise ready 0, data 0.
REQ-031 out_valid SHALL hold with stable fields until out_ready is high at an edge.
REQ-032 fwd_* SHALL show the output register when out_valid is high, else id 0, ready 1, data 0.

Reset
REQ-033 Reset SHALL force state IDLE, out_valid 0, dm_req 0, out_misaligned 0, all other outputs 0 on the next edge.
REQ-034 Reset during ACCESS SHALL abandon the access; a dm_ack in the reset cycle SHALL be ignored.

Configuration
REQ-035 With MEM_MISALIGN_TRAP_EN defined, an access whose address is not a multiple of its size SHALL not assert dm_req and SHALL reach the output after 1 cycle with out_misaligned 1, out_rw_ready 1, out_rw_data 0.
REQ-036 Without MEM_MISALIGN_TRAP_EN, misaligned accesses SHALL proceed using the low address bits truncated to the access size; out_misaligned SHALL be 0.

Verification
REQ-037 ALU op, rw_id 3, in_rw_ready 1, data 0x55 -> next cycle out_valid 1, fwd_id 3, fwd_data 0x55.
REQ-038 Byte load addr 0x103, dm_rdata 0x80000000, in_unsigned 0, ack 3 cycles after req -> out_rw_data 0xFFFFFF80, in_ready low throughout ACCESS.
REQ-039 Half store addr 0x102, data 0x1234ABCD -> dm_wstrb 0b1100, dm_wdata 0xABCDABCD, dm_addr 0x100, dm_we 1.
REQ-040 out_ready low for 4 cycles with result held -> in_ready 0, outputs unchanged, result consumed on the first edge with out_ready high.
REQ-041 Reset asserted mid-ACCESS with dm_ack coincident -> dm_req 0, out_valid 0 next cycle, no result emitted.
REQ-042 MEM_MISALIGN_TRAP_EN, word load addr 0x102 -> dm_req never asserts, out_misaligned 1 after 1 cycle.
